// File: rtl/prbs_pkg.sv
// Shared PRBS-8 definitions: checker state encoding, generator tap mask and lock-up state.
// Generator and checker both take the polynomial x^8+x^6+x^5+x^4+1 from here.
package prbs_pkg;

  typedef enum logic [1:0] {
    ST_SEED   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } prbs_state_e;

  localparam logic [7:0] PRBS8_TAPS = 8'b1011_1000;
  localparam logic [7:0] PRBS8_ZERO = 8'h00;

  // Next bit a left-shifting PRBS-8 register produces from state sr.
  function automatic logic prbs8_predict(input logic [7:0] sr);
    return ^(sr & PRBS8_TAPS);
  endfunction

endpackage

// File: rtl/prbs_sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module prbs_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         clear_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising serial PRBS-8 checker: seed, verify, then count errors against a free-running LFSR.
// Define PRBS_CHECKER_STATS_EN to build the checked-bit counter behind bit_count_o.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_CNT = 16,
  parameter int LOSS_CNT = 4,
  parameter int ERR_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             bit_i,
  input  logic             valid_i,
  input  logic             clear_i,
  output logic             locked_o,
  output logic             err_o,
  output logic [ERR_W-1:0] err_count_o,
  output logic [31:0]      bit_count_o
);

  localparam logic [7:0] RUN_LAST  = 8'(LOCK_CNT - 1);
  localparam logic [3:0] MISS_LAST = 4'(LOSS_CNT - 1);

  prbs_state_e state_d, state_q;
  logic [7:0]  sr_d, sr_q;
  logic [3:0]  seed_cnt_d, seed_cnt_q;
  logic [7:0]  run_cnt_d, run_cnt_q;
  logic [3:0]  miss_cnt_d, miss_cnt_q;
  logic        err_d, err_q;
  logic        pred;
  logic        mismatch;

  assign pred     = prbs8_predict(sr_q);
  assign mismatch = bit_i ^ pred;

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    seed_cnt_d = seed_cnt_q;
    run_cnt_d  = run_cnt_q;
    miss_cnt_d = miss_cnt_q;
    err_d      = 1'b0;
    if (valid_i) begin
      case (state_q)
        ST_SEED: begin
          sr_d = {sr_q[6:0], bit_i};
          if (seed_cnt_q == 4'd7) begin
            seed_cnt_d = '0;
            // An all-zero seed is the LFSR lock-up state; keep seeding.
            if (sr_d != PRBS8_ZERO) begin
              state_d   = ST_VERIFY;
              run_cnt_d = '0;
            end
          end else begin
            seed_cnt_d = seed_cnt_q + 4'd1;
          end
        end
        ST_VERIFY: begin
          sr_d = {sr_q[6:0], bit_i};
          if (mismatch) begin
            state_d    = ST_SEED;
            seed_cnt_d = '0;
          end else if (run_cnt_q == RUN_LAST) begin
            state_d    = ST_LOCKED;
            miss_cnt_d = '0;
          end else begin
            run_cnt_d = run_cnt_q + 8'd1;
          end
        end
        ST_LOCKED: begin
          // Free-run on the prediction so line errors never corrupt the reference.
          sr_d = {sr_q[6:0], pred};
          if (mismatch) begin
            err_d = 1'b1;
            if (miss_cnt_q == MISS_LAST) begin
              state_d    = ST_SEED;
              seed_cnt_d = '0;
              miss_cnt_d = '0;
            end else begin
              miss_cnt_d = miss_cnt_q + 4'd1;
            end
          end else begin
            miss_cnt_d = '0;
          end
        end
        default: begin
          state_d    = ST_SEED;
          seed_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_SEED;
      sr_q       <= '0;
      seed_cnt_q <= '0;
      run_cnt_q  <= '0;
      miss_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      seed_cnt_q <= seed_cnt_d;
      run_cnt_q  <= run_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      err_q      <= err_d;
    end
  end

  assign locked_o = (state_q == ST_LOCKED);
  assign err_o    = err_q;

  prbs_sat_counter #(
    .W(ERR_W)
  ) u_err_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (err_d),
    .clear_i (clear_i),
    .count_o (err_count_o)
  );

`ifdef PRBS_CHECKER_STATS_EN
  logic [31:0] bit_count_d, bit_count_q;

  always_comb begin
    bit_count_d = bit_count_q;
    if (clear_i) begin
      bit_count_d = '0;
    end else if (valid_i && (state_q == ST_LOCKED)) begin
      bit_count_d = bit_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bit_count_q <= '0;
    end else begin
      bit_count_q <= bit_count_d;
    end
  end

  assign bit_count_o = bit_count_q;
`else
  assign bit_count_o = '0;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: PRBS-8 stream with random gaps and directed corruption, checked against a stream-recurrence model.
module tb_prbs_checker;

  localparam int LOCK_CNT = 16;
  localparam int LOSS_CNT = 4;
  localparam int M_SEED = 0, M_VERIFY = 1, M_LOCKED = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bit_in = 1'b0;
  logic        valid = 1'b0;
  logic        clear = 1'b0;
  logic        locked_a, err_a, locked_b, err_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;
  logic [31:0] bits_a, bits_b;

  int vectors = 0;
  int miscompares = 0;

  prbs_checker dut_a (
    .clk_i(clk), .rst_i(rst), .bit_i(bit_in), .valid_i(valid), .clear_i(clear),
    .locked_o(locked_a), .err_o(err_a), .err_count_o(cnt_a), .bit_count_o(bits_a)
  );

  prbs_checker #(.ERR_W(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .bit_i(bit_in), .valid_i(valid), .clear_i(clear),
    .locked_o(locked_b), .err_o(err_b), .err_count_o(cnt_b), .bit_count_o(bits_b)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: last eight reference bits, oldest first.
  bit          m_hist[$];
  int          m_mode, m_seed_n, m_run, m_miss;
  bit          m_err;
  int          m_cnt_a, m_cnt_b;
  logic [31:0] m_bits;
  int          pulses_a;
  logic [7:0]  gen;

  task automatic model_reset();
    m_hist.delete();
    repeat (8) m_hist.push_back(1'b0);
    m_mode = M_SEED; m_seed_n = 0; m_run = 0; m_miss = 0;
    m_err = 0; m_cnt_a = 0; m_cnt_b = 0; m_bits = '0;
  endtask

  task automatic push(input bit x);
    m_hist.push_back(x);
    void'(m_hist.pop_front());
  endtask

  task automatic model_step(input bit b, input bit v, input bit c);
    bit p;
    int ones;
    m_err = 0;
    if (v) begin
      // b[n] = b[n-8] ^ b[n-6] ^ b[n-5] ^ b[n-4]
      p = m_hist[0] ^ m_hist[2] ^ m_hist[3] ^ m_hist[4];
      if (m_mode == M_SEED) begin
        push(b);
        m_seed_n++;
        if (m_seed_n == 8) begin
          m_seed_n = 0;
          ones = 0;
          foreach (m_hist[i]) ones += int'(m_hist[i]);
          if (ones != 0) begin
            m_mode = M_VERIFY;
            m_run = 0;
          end
        end
      end else if (m_mode == M_VERIFY) begin
        push(b);
        if (b == p) begin
          m_run++;
          if (m_run == LOCK_CNT) begin
            m_mode = M_LOCKED;
            m_miss = 0;
          end
        end else begin
          m_mode = M_SEED;
          m_seed_n = 0;
        end
      end else begin
        push(p);
        m_bits = m_bits + 32'd1;
        if (b != p) begin
          m_err = 1;
          if (m_cnt_a < 65535) m_cnt_a++;
          if (m_cnt_b < 15) m_cnt_b++;
          m_miss++;
          if (m_miss == LOSS_CNT) begin
            m_mode = M_SEED;
            m_seed_n = 0;
          end
        end else begin
          m_miss = 0;
        end
      end
    end
    if (c) begin
      m_cnt_a = 0; m_cnt_b = 0; m_bits = '0;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] exp_bits;
`ifdef PRBS_CHECKER_STATS_EN
    exp_bits = m_bits;
`else
    exp_bits = '0;
`endif
    check("locked_a", 64'(locked_a), 64'(m_mode == M_LOCKED));
    check("locked_b", 64'(locked_b), 64'(m_mode == M_LOCKED));
    check("err_a", 64'(err_a), 64'(m_err));
    check("err_b", 64'(err_b), 64'(m_err));
    check("cnt_a", 64'(cnt_a), 64'(m_cnt_a));
    check("cnt_b", 64'(cnt_b), 64'(m_cnt_b));
    check("bits_a", 64'(bits_a), 64'(exp_bits));
    check("bits_b", 64'(bits_b), 64'(exp_bits));
    if (err_a === 1'b1) pulses_a++;
  endtask

  task automatic apply(input bit b, input bit v, input bit c);
    bit_in = b; valid = v; clear = c;
    @(posedge clk);
    model_step(b, v, c);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1; valid = 1'b0; clear = 1'b0;
    @(posedge clk);
    model_reset();
    gen = 8'hFF;
    #1;
    check_all();
    check("rst_locked", 64'(locked_a), 64'd0);
    check("rst_err", 64'(err_a), 64'd0);
    check("rst_cnt", 64'(cnt_a), 64'd0);
    check("rst_bits", 64'(bits_a), 64'd0);
    rst = 1'b0;
  endtask

  task automatic gen_bit(output bit b);
    b = gen[0];
    gen = {gen[6:0], gen[7] ^ gen[5] ^ gen[4] ^ gen[3]};
  endtask

  // n generator bits; with gaps, random idle cycles carrying junk bits are interleaved.
  task automatic clean(input int n, input bit gaps);
    bit b;
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(7) == 0)) apply(1'($urandom), 1'b0, 1'b0);
      gen_bit(b);
      apply(b, 1'b1, 1'b0);
    end
  endtask

  task automatic corrupt(input bit c);
    bit b;
    gen_bit(b);
    apply(~b, 1'b1, c);
  endtask

  initial begin
    int p0;
    model_reset();
    pulses_a = 0;
    gen = 8'hFF;
    do_reset();
    do_reset();

    // Lock timing with continuous valid: locked_o rises after bit 23.
    clean(23, 1'b0);
    check("lock_before_24", 64'(locked_a), 64'd0);
    clean(1, 1'b0);
    check("lock_at_24", 64'(locked_a), 64'd1);
    clean(976, 1'b1);
    check("clean_cnt", 64'(cnt_a), 64'd0);
    check("clean_pulses", 64'(pulses_a), 64'd0);

    // Single inverted bit.
    p0 = pulses_a;
    clean($urandom_range(20, 5), 1'b1);
    corrupt(1'b0);
    clean(10, 1'b1);
    check("single_pulses", 64'(pulses_a - p0), 64'd1);
    check("single_cnt", 64'(cnt_a), 64'd1);
    check("single_locked", 64'(locked_a), 64'd1);

    // Four consecutive inverted bits drop lock on the fourth.
    p0 = pulses_a;
    corrupt(1'b0); corrupt(1'b0); corrupt(1'b0);
    check("loss_still_locked", 64'(locked_a), 64'd1);
    corrupt(1'b0);
    check("loss_locked", 64'(locked_a), 64'd0);
    check("loss_pulses", 64'(pulses_a - p0), 64'd4);
    check("loss_cnt", 64'(cnt_a), 64'd5);
    clean(23, 1'b0);
    check("relock_before", 64'(locked_a), 64'd0);
    clean(1, 1'b0);
    check("relock_at_24", 64'(locked_a), 64'd1);

    // All-zero stream never leaves SEED.
    do_reset();
    repeat (64) apply(1'b0, 1'b1, 1'b0);
    check("zeros_locked", 64'(locked_a), 64'd0);
    check("zeros_cnt", 64'(cnt_a), 64'd0);

    // Corruption inside the VERIFY window restarts seeding without counting.
    clean(12, 1'b0);
    corrupt(1'b0);
    check("verify_cnt", 64'(cnt_a), 64'd0);
    check("verify_err", 64'(err_a), 64'd0);
    clean(23, 1'b0);
    check("verify_relock_before", 64'(locked_a), 64'd0);
    clean(1, 1'b0);
    check("verify_relock", 64'(locked_a), 64'd1);

    // Twenty isolated errors saturate the 4-bit counter.
    for (int i = 0; i < 20; i++) begin
      corrupt(1'b0);
      clean($urandom_range(4, 1), 1'b1);
    end
    check("sat_cnt_a", 64'(cnt_a), 64'd20);
    check("sat_cnt_b", 64'(cnt_b), 64'd15);
    check("sat_locked", 64'(locked_a), 64'd1);

    // Clear on an error cycle: count goes to 0, pulse still fires.
    corrupt(1'b1);
    check("clr_err", 64'(err_a), 64'd1);
    check("clr_cnt_a", 64'(cnt_a), 64'd0);
    check("clr_cnt_b", 64'(cnt_b), 64'd0);
    clean(3, 1'b0);

    // Reset while locked.
    do_reset();
    check("rst_mid_locked_b", 64'(locked_b), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
